// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single-port, 1-cycle-latency RAM between an
// instruction-fetch port (0) and a data port (1), with a bounded port-1 lock.
module mem_arbiter #(
  parameter int DATA_WIDTH = 12,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [DATA_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [DATA_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  input  logic                  p1_lock,
  output logic                  lock_timeout,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  typedef enum logic {ARB, LOCKED} state_t;

  state_t           state;
  logic             last_grant;
  logic             rd_pending;
  logic             rd_owner;
  logic             lock_block;
  logic [CNT_W-1:0] lock_cnt;

  logic grant0, grant1;
  logic hold_lock;
  logic timeout_now;

  // The lock only holds while p1 keeps p1_lock asserted; the cycle it drops,
  // port 0 already gets priority so a waiting fetch is not delayed further.
  assign hold_lock   = (state == LOCKED) & p1_lock;
  assign timeout_now = hold_lock & (lock_cnt == CNT_W'(LOCK_MAX - 1)) & ~rst;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (hold_lock) begin
        grant1 = p1_req;
      end else if (state == LOCKED) begin
        grant0 = p0_req;
        grant1 = p1_req & ~p0_req;
      end else if (p0_req & p1_req) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = p0_req;
        grant1 = p1_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      last_grant <= 1'b1;
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
      lock_cnt   <= '0;
      lock_block <= 1'b0;
    end else begin
      rd_pending <= (grant0 & ~p0_we) | (grant1 & ~p1_we);
      if (grant0 | grant1) begin
        rd_owner   <= grant1;
        last_grant <= grant1;
      end
      if (!p1_lock) lock_block <= 1'b0;
      case (state)
        ARB: begin
          if (grant1 & p1_lock & ~lock_block) begin
            state    <= LOCKED;
            lock_cnt <= '0;
          end
        end
        LOCKED: begin
          if (!p1_lock) begin
            state <= ARB;
            if (!grant0) last_grant <= 1'b1;
          end else if (timeout_now) begin
            // Forced release: p1 must drop p1_lock before it may relock.
            state      <= ARB;
            lock_block <= 1'b1;
            last_grant <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign p0_gnt       = grant0;
  assign p1_gnt       = grant1;
  assign lock_timeout = timeout_now;

  assign mem_we    = grant0 ? p0_we    : (grant1 ? p1_we    : 1'b0);
  assign mem_addr  = grant0 ? p0_addr  : (grant1 ? p1_addr  : '0);
  assign mem_wdata = grant0 ? p0_wdata : (grant1 ? p1_wdata : '0);

  // A read in flight when reset arrives is dropped.
  assign p0_rvalid = rd_pending & ~rd_owner & ~rst;
  assign p1_rvalid = rd_pending &  rd_owner & ~rst;
  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model of the arbitration and lock rules.
module tb_mem_arbiter;
  localparam int DW = 12;
  localparam int LM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p0_req = 1'b0, p0_we = 1'b0;
  logic [DW-1:0] p0_addr = '0, p0_wdata = '0;
  logic          p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
  logic [DW-1:0] p1_addr = '0, p1_wdata = '0;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, lock_timeout, mem_we;
  logic [DW-1:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [DW-1:0] ram     [0:4095];
  logic [DW-1:0] ref_mem [0:4095];

  int checks = 0;
  int failures = 0;

  // reference model state
  bit            m_locked, m_blocked, m_prio;
  int            m_age, m_rd_owner;
  logic [DW-1:0] m_rd_data;
  logic          eg0, eg1, eto, ewe;
  logic [DW-1:0] eaddr, ewdata;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(DW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .p1_lock(p1_lock), .lock_timeout(lock_timeout),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic set_p0(input logic req, input logic we, input logic [DW-1:0] addr,
                        input logic [DW-1:0] wdata);
    p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
  endtask

  task automatic set_p1(input logic req, input logic we, input logic [DW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic lock);
    p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_lock = lock;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_p0(0, 0, '0, '0);
    set_p1(0, 0, '0, '0, 0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_p0(1, 1, 12'h010, 12'h111);
    set_p1(1, 1, 12'h011, 12'h222, 1);
    next_cycle();
    @(negedge clk);
    checks++; if (p0_gnt !== 1'b0) begin failures++; $display("FAIL reset_p0_gnt got=%b exp=0", p0_gnt); end
    checks++; if (p1_gnt !== 1'b0) begin failures++; $display("FAIL reset_p1_gnt got=%b exp=0", p1_gnt); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (p0_rvalid !== 1'b0) begin failures++; $display("FAIL reset_p0_rvalid got=%b exp=0", p0_rvalid); end
    checks++; if (p1_rvalid !== 1'b0) begin failures++; $display("FAIL reset_p1_rvalid got=%b exp=0", p1_rvalid); end
    checks++; if (lock_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", lock_timeout); end
    do_reset();
  endtask

  task automatic test_read_basic();
    do_reset();
    set_p0(1, 0, 12'h010, '0);
    @(negedge clk);
    checks++; if (p0_gnt !== 1'b1) begin failures++; $display("FAIL rd_p0_gnt got=%b exp=1", p0_gnt); end
    checks++; if (mem_addr !== 12'h010) begin failures++; $display("FAIL rd_mem_addr got=%h exp=010", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rd_mem_we got=%b exp=0", mem_we); end
    next_cycle();
    set_p0(0, 0, '0, '0);
    @(negedge clk);
    checks++; if (p0_rvalid !== 1'b1) begin failures++; $display("FAIL rd_p0_rvalid got=%b exp=1", p0_rvalid); end
    checks++; if (p0_rdata !== 12'hABC) begin failures++; $display("FAIL rd_p0_rdata got=%h exp=abc", p0_rdata); end
    checks++; if (p1_rvalid !== 1'b0) begin failures++; $display("FAIL rd_p1_rvalid got=%b exp=0", p1_rvalid); end
    checks++; if (mem_addr !== 12'h000 || mem_wdata !== 12'h000) begin
      failures++; $display("FAIL idle_mem_bus got=%h/%h exp=000/000", mem_addr, mem_wdata); end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic e0;
    do_reset();
    set_p0(1, 0, 12'h030, '0);
    set_p1(1, 0, 12'h031, '0, 0);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k < 6) begin
        e0 = (k % 2 == 0);
        checks++; if (p0_gnt !== e0 || p1_gnt !== ~e0) begin
          failures++; $display("FAIL rr_gnt cyc=%0d got=%b%b exp=%b%b", k, p0_gnt, p1_gnt, e0, ~e0); end
      end
      if (k > 0) begin
        e0 = (k % 2 == 1);
        checks++; if (p0_rvalid !== e0 || p1_rvalid !== ~e0) begin
          failures++; $display("FAIL rr_rvalid cyc=%0d got=%b%b exp=%b%b", k, p0_rvalid, p1_rvalid, e0, ~e0); end
        checks++; if (p0_rdata !== (e0 ? 12'h111 : 12'h222)) begin
          failures++; $display("FAIL rr_rdata cyc=%0d got=%h exp=%h", k, p0_rdata, e0 ? 12'h111 : 12'h222); end
      end
      next_cycle();
      if (k == 5) begin
        set_p0(0, 0, '0, '0);
        set_p1(0, 0, '0, '0, 0);
      end
    end
  endtask

  task automatic test_write_read();
    do_reset();
    set_p1(1, 1, 12'h020, 12'h5A5, 0);
    @(negedge clk);
    checks++; if (p1_gnt !== 1'b1 || mem_we !== 1'b1) begin
      failures++; $display("FAIL wr_gnt_we got=%b%b exp=11", p1_gnt, mem_we); end
    checks++; if (mem_addr !== 12'h020 || mem_wdata !== 12'h5A5) begin
      failures++; $display("FAIL wr_bus got=%h/%h exp=020/5a5", mem_addr, mem_wdata); end
    next_cycle();
    set_p1(1, 0, 12'h020, '0, 0);
    @(negedge clk);
    checks++; if (p1_gnt !== 1'b1 || mem_we !== 1'b0) begin
      failures++; $display("FAIL wr_rd_gnt got=%b%b exp=10", p1_gnt, mem_we); end
    next_cycle();
    set_p1(0, 0, '0, '0, 0);
    @(negedge clk);
    checks++; if (p1_rvalid !== 1'b1 || p0_rvalid !== 1'b0) begin
      failures++; $display("FAIL wr_rvalid got=%b%b exp=10", p1_rvalid, p0_rvalid); end
    checks++; if (p1_rdata !== 12'h5A5) begin failures++; $display("FAIL wr_rdata got=%h exp=5a5", p1_rdata); end
    next_cycle();
  endtask

  task automatic test_lock_release();
    do_reset();
    set_p0(1, 0, 12'h040, '0);
    @(negedge clk);
    checks++; if (p0_gnt !== 1'b1) begin failures++; $display("FAIL lk_pre_p0 got=%b exp=1", p0_gnt); end
    next_cycle();
    set_p1(1, 0, 12'h041, '0, 1);
    @(negedge clk);
    checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b1) begin
      failures++; $display("FAIL lk_n0 got=%b%b exp=01", p0_gnt, p1_gnt); end
    next_cycle();
    set_p1(1, 1, 12'h041, 12'h777, 1);
    @(negedge clk);
    checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b1 || mem_we !== 1'b1) begin
      failures++; $display("FAIL lk_n1 got=%b%b%b exp=011", p0_gnt, p1_gnt, mem_we); end
    next_cycle();
    set_p1(1, 0, 12'h041, '0, 0);
    @(negedge clk);
    checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
      failures++; $display("FAIL lk_n2 got=%b%b exp=10", p0_gnt, p1_gnt); end
    next_cycle();
    set_p0(0, 0, '0, '0);
    @(negedge clk);
    checks++; if (p1_gnt !== 1'b1) begin failures++; $display("FAIL lk_n3 got=%b exp=1", p1_gnt); end
    next_cycle();
    set_p1(0, 0, '0, '0, 0);
    @(negedge clk);
    checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== 12'h777) begin
      failures++; $display("FAIL lk_rmw got=%b/%h exp=1/777", p1_rvalid, p1_rdata); end
    next_cycle();
  endtask

  task automatic test_lock_timeout();
    do_reset();
    set_p0(1, 0, 12'h050, '0);
    next_cycle();
    set_p1(1, 0, 12'h051, '0, 1);
    @(negedge clk);
    checks++; if (p1_gnt !== 1'b1) begin failures++; $display("FAIL to_enter got=%b exp=1", p1_gnt); end
    next_cycle();
    for (int k = 0; k < LM; k++) begin
      @(negedge clk);
      checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b1) begin
        failures++; $display("FAIL to_locked k=%0d got=%b%b exp=01", k, p0_gnt, p1_gnt); end
      checks++; if (lock_timeout !== (k == LM - 1)) begin
        failures++; $display("FAIL to_pulse k=%0d got=%b exp=%b", k, lock_timeout, k == LM - 1); end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (p0_gnt !== 1'b1 || lock_timeout !== 1'b0) begin
      failures++; $display("FAIL to_p0_after got=%b/%b exp=1/0", p0_gnt, lock_timeout); end
    next_cycle();
    @(negedge clk);
    checks++; if (p1_gnt !== 1'b1) begin failures++; $display("FAIL to_p1_norelock got=%b exp=1", p1_gnt); end
    next_cycle();
    @(negedge clk);
    checks++; if (p0_gnt !== 1'b1 || lock_timeout !== 1'b0) begin
      failures++; $display("FAIL to_blocked got=%b/%b exp=1/0", p0_gnt, lock_timeout); end
    next_cycle();
    set_p0(0, 0, '0, '0);
    set_p1(0, 0, '0, '0, 0);
    next_cycle();
    set_p1(1, 0, 12'h051, '0, 1);
    @(negedge clk);
    checks++; if (p1_gnt !== 1'b1) begin failures++; $display("FAIL to_relock got=%b exp=1", p1_gnt); end
    next_cycle();
    set_p0(1, 0, 12'h050, '0);
    @(negedge clk);
    checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b1) begin
      failures++; $display("FAIL to_relocked got=%b%b exp=01", p0_gnt, p1_gnt); end
    next_cycle();
    set_p0(0, 0, '0, '0);
    set_p1(0, 0, '0, '0, 0);
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_p0(1, 0, 12'h010, '0);
    @(negedge clk);
    checks++; if (p0_gnt !== 1'b1) begin failures++; $display("FAIL rm_gnt got=%b exp=1", p0_gnt); end
    next_cycle();
    rst = 1'b1;
    set_p0(1, 1, 12'h010, 12'h123);
    set_p1(1, 1, 12'h011, 12'h456, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (p0_rvalid !== 1'b0) begin failures++; $display("FAIL rm_rvalid k=%0d got=%b exp=0", k, p0_rvalid); end
      checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0 || mem_we !== 1'b0) begin
        failures++; $display("FAIL rm_quiet k=%0d got=%b%b%b exp=000", k, p0_gnt, p1_gnt, mem_we); end
      next_cycle();
    end
    rst = 1'b0;
    set_p0(0, 0, '0, '0);
    set_p1(1, 0, 12'h060, '0, 1);
    @(negedge clk);
    checks++; if (p0_rvalid !== 1'b0 || p1_gnt !== 1'b1) begin
      failures++; $display("FAIL rm_after got=%b/%b exp=0/1", p0_rvalid, p1_gnt); end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    set_p0(1, 0, 12'h010, '0);
    @(negedge clk);
    checks++; if (p0_gnt !== 1'b1) begin failures++; $display("FAIL rm_unlock got=%b exp=1", p0_gnt); end
    next_cycle();
    set_p0(0, 0, '0, '0);
    set_p1(0, 0, '0, '0, 0);
    @(negedge clk);
    checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 12'hABC) begin
      failures++; $display("FAIL rm_ram_kept got=%b/%h exp=1/abc", p0_rvalid, p0_rdata); end
    next_cycle();
  endtask

  // Expected outputs for the current cycle from the model state and inputs.
  task automatic predict();
    eg0 = 1'b0; eg1 = 1'b0; eto = 1'b0;
    if (!rst) begin
      if (m_locked && p1_lock) begin
        eg1 = p1_req;
        eto = (m_age == LM - 1);
      end else if (m_locked) begin
        eg0 = p0_req;
        eg1 = p1_req && !p0_req;
      end else if (p0_req && p1_req) begin
        eg0 = (m_prio == 1'b0);
        eg1 = (m_prio == 1'b1);
      end else begin
        eg0 = p0_req;
        eg1 = p1_req;
      end
    end
    ewe = eg0 ? p0_we : (eg1 ? p1_we : 1'b0);
    eaddr = eg0 ? p0_addr : (eg1 ? p1_addr : '0);
    ewdata = eg0 ? p0_wdata : (eg1 ? p1_wdata : '0);
  endtask

  // Advance the model across the clock edge using this cycle's inputs.
  task automatic commit();
    if (rst) begin
      m_locked = 0; m_blocked = 0; m_prio = 0; m_age = 0; m_rd_owner = -1;
      return;
    end
    m_rd_owner = -1;
    if ((eg0 || eg1) && !ewe) begin
      m_rd_owner = eg1 ? 1 : 0;
      m_rd_data = ref_mem[eaddr];
    end
    if ((eg0 || eg1) && ewe) ref_mem[eaddr] = ewdata;
    if (eg0) m_prio = 1;
    if (eg1) m_prio = 0;
    if (m_locked) begin
      if (!p1_lock) begin
        m_locked = 0;
        if (!eg0) m_prio = 0;
      end else if (m_age == LM - 1) begin
        m_locked = 0; m_blocked = 1; m_prio = 0;
      end else begin
        m_age++;
      end
    end else if (eg1 && p1_lock && !m_blocked) begin
      m_locked = 1; m_age = 0;
    end
    if (!p1_lock) m_blocked = 0;
  endtask

  task automatic test_random();
    logic last_g0, last_g1;
    do_reset();
    for (int i = 0; i < 4096; i++) ref_mem[i] = ram[i];
    m_locked = 0; m_blocked = 0; m_prio = 0; m_age = 0; m_rd_owner = -1;
    last_g0 = 1'b0; last_g1 = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!(p0_req && !last_g0))
        set_p0($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
               DW'($urandom_range(0, 15)), DW'($urandom));
      if (!(p1_req && !last_g1))
        set_p1($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
               DW'($urandom_range(0, 15)), DW'($urandom), p1_lock);
      if ($urandom_range(0, 7) == 0) p1_lock = ~p1_lock;
      predict();
      @(negedge clk);
      checks++; if (p0_gnt !== eg0 || p1_gnt !== eg1) begin
        failures++; $display("FAIL rnd_gnt cyc=%0d got=%b%b exp=%b%b", cyc, p0_gnt, p1_gnt, eg0, eg1); end
      checks++; if (mem_we !== ewe || mem_addr !== eaddr || mem_wdata !== ewdata) begin
        failures++; $display("FAIL rnd_bus cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc,
                             mem_we, mem_addr, mem_wdata, ewe, eaddr, ewdata); end
      checks++; if (p0_rvalid !== (m_rd_owner == 0 && !rst) || p1_rvalid !== (m_rd_owner == 1 && !rst)) begin
        failures++; $display("FAIL rnd_rvalid cyc=%0d got=%b%b exp_owner=%0d rst=%b", cyc,
                             p0_rvalid, p1_rvalid, m_rd_owner, rst); end
      if (m_rd_owner >= 0 && !rst) begin
        checks++; if (p0_rdata !== m_rd_data || p1_rdata !== m_rd_data) begin
          failures++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, p0_rdata, m_rd_data); end
      end
      checks++; if (lock_timeout !== eto) begin
        failures++; $display("FAIL rnd_timeout cyc=%0d got=%b exp=%b", cyc, lock_timeout, eto); end
      last_g0 = p0_gnt;
      last_g1 = p1_gnt;
      @(posedge clk);
      commit();
      #1;
    end
    rst = 1'b0;
    set_p0(0, 0, '0, '0);
    set_p1(0, 0, '0, '0, 0);
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = DW'(i * 7 + 3);
    ram[12'h010] = 12'hABC;
    ram[12'h030] = 12'h111;
    ram[12'h031] = 12'h222;
    test_reset();
    test_read_basic();
    test_round_robin();
    test_write_read();
    test_lock_release();
    test_lock_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port, 1-cycle-read-latency RAM between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Arbitrates round-robin and drives the RAM address, write-enable and write-data lines.
- Routes registered read data back to the port that issued the read.
- Port 1 can lock the RAM for atomic read-modify-write sequences; a bounded timeout forces the lock to release.

Parameters:
- DATA_WIDTH, 12, width of RAM words, addresses and all data ports.
- LOCK_MAX, 16, maximum consecutive cycles in LOCKED before forced release (>=1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- p0_req  in  1  port 0 request valid.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  DATA_WIDTH  port 0 address.
- p0_wdata  in  DATA_WIDTH  port 0 write data.
- p0_gnt  out  1  port 0 request accepted this cycle (combinational).
- p0_rvalid  out  1  port 0 read data valid.
- p0_rdata  out  DATA_WIDTH  port 0 read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- p1_lock  in  1  port 1 requests exclusive ownership.
- lock_timeout  out  1  one-cycle pulse when the lock is forcibly released.
- mem_addr  out  DATA_WIDTH  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after the address is sampled.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=ARB, last_grant=1 so port 0 wins the first tie, rd_pending=0, lock_cnt=0, lock_block=0.
  - Registered outputs after reset: p0_rvalid=0, p1_rvalid=0, lock_timeout=0.
  - While rst=1, both gnt=0 and mem_we=0.
- Handshake:
  - A requester holds req/we/addr/wdata stable until gnt=1 in the same cycle. Transfer occurs on any cycle with req & gnt.
  - gnt never asserts without req.
  - At most one gnt per cycle; a new request may be granted every cycle (fully pipelined).
- Memory drive (combinational from the winner):
  - With a winner: mem_addr/mem_we/mem_wdata = winner's addr/we/wdata.
  - With no winner: mem_we=0, mem_addr=0, mem_wdata=0.
- Read return:
  - On a granted read, rd_pending<=1 and rd_owner<=winner; otherwise rd_pending<=0.
  - pX_rvalid = rd_pending & (rd_owner==X). Read latency is exactly 1 cycle after gnt.
  - p0_rdata = p1_rdata = mem_rdata; contents are meaningful only while rvalid=1.
- Write completion:
  - A write completes at the grant edge, with no response.
  - A read issued the following cycle to the same address returns the new data.
- ARB state:
  - Both req: grant the port != last_grant. One req: grant it. None: idle.
  - On every grant, last_grant<=winner.
  - If p1 is granted with p1_lock=1 and lock_block=0: go to LOCKED, lock_cnt<=0.
- LOCKED state:
  - p0_gnt=0. p1 is granted whenever p1_req=1. lock_cnt increments every cycle.
  - p1_lock=0 sampled: go to ARB with last_grant<=1, so a waiting p0 wins next.
  - lock_cnt==LOCK_MAX-1 with p1_lock=1: go to ARB, lock_timeout=1 for one cycle, lock_block<=1, last_grant<=1.
  - The timeout cycle itself still grants p1 if it requests.
- lock_block:
  - Clears when p1_lock is sampled 0.
  - While set, p1_lock is ignored and ARB arbitrates normally.
- Reset mid-operation: a pending read is dropped (no rvalid), and the lock is released.

Test Plan:
- RAM preloaded with [0x010]=0xABC. p0 read 0x010 at cycle N -> p0_gnt=1 at N, mem_addr=0x010, p0_rvalid=1 with 0xABC at N+1, p1_rvalid=0.
- p0 and p1 both hold read requests for 6 cycles after reset -> grants alternate p0,p1,p0,p1,p0,p1. Each rvalid appears 1 cycle after its grant, on the correct port.
- p1 writes 0x5A5 to 0x020 at N, then reads 0x020 at N+1 -> mem_we=1 at N, p1_rvalid=1 with 0x5A5 at N+2.
- p1 read with lock=1 at N, write at N+1, lock=0 at N+2, while p0_req is held throughout -> p0_gnt=0 at N..N+1, p0_gnt=1 at N+2 (p1 not granted at N+2 if it requests).
- LOCK_MAX=4, p1_lock held high with p0 requesting -> lock_timeout pulses once at N+3, p0 granted at N+4. A p1 relock is refused until p1_lock drops.
- p0 read granted at N, rst=1 at N+1 -> p0_rvalid=0 at N+1 and after; gnt=0 and mem_we=0 during reset.
